// File: rtl/deal_controller.sv
// -----------------------------------------------------------------------------
// deal_controller
//
// Control FSM for the baccarat table. It deals four cards into the datapath in
// a fixed order. It then applies the third-card (tableau) rules to the scores
// read back from the datapath. Once the hand is complete it lights the win
// LEDs.
//
// Handshake: there is no valid/ready pair. Each load_* strobe is high for
// exactly one slow_clock cycle, and the datapath captures the card on the
// rising edge that ends that cycle. The datapath scores are combinational from
// its card registers, so the FSM sees them in the state after a load.
//
// Ports
//   slow_clock        in   sole clock, rising edge
//   resetb            in   asynchronous active-low reset
//   pscore[3:0]       in   player hand score 0..9
//   dscore[3:0]       in   dealer hand score 0..9
//   pcard3[3:0]       in   player third-card rank 0..13 (1=A, 11..13=J/Q/K)
//   load_pcard1..3    out  load player card 1..3 on the next edge
//   load_dcard1..3    out  load dealer card 1..3 on the next edge
//   player_win_light  out  player wins or tie (DONE only)
//   dealer_win_light  out  dealer wins or tie (DONE only)
// -----------------------------------------------------------------------------
module deal_controller (
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       player_win_light,
    output logic       dealer_win_light
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_P1     = 4'd1,
        S_D1     = 4'd2,
        S_P2     = 4'd3,
        S_D2     = 4'd4,
        S_EVAL   = 4'd5,
        S_P3     = 4'd6,
        S_EVAL_B = 4'd7,
        S_D3     = 4'd8,
        S_DONE   = 4'd9
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] w_v;          // player third-card value, where 10/J/Q/K count as 0
    logic       w_natural;
    logic       w_dealer_draws;

    // Tableau helpers
    always_comb begin
        w_v       = (pcard3 <= 4'd9) ? pcard3 : 4'd0;
        w_natural = (pscore == 4'd8) || (pscore == 4'd9) ||
                    (dscore == 4'd8) || (dscore == 4'd9);
        w_dealer_draws = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: w_dealer_draws = 1'b1;
            4'd3:             w_dealer_draws = (w_v != 4'd8);
            4'd4:             w_dealer_draws = (w_v >= 4'd2) && (w_v <= 4'd7);
            4'd5:             w_dealer_draws = (w_v >= 4'd4) && (w_v <= 4'd7);
            4'd6:             w_dealer_draws = (w_v == 4'd6) || (w_v == 4'd7);
            default:          w_dealer_draws = 1'b0;  // 7 always stands
        endcase
    end

    // State register
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = S_P1;
            S_P1:     w_next = S_D1;
            S_D1:     w_next = S_P2;
            S_P2:     w_next = S_D2;
            S_D2:     w_next = S_EVAL;
            S_EVAL: begin
                if (w_natural)                 w_next = S_DONE;
                else if (pscore <= 4'd5)       w_next = S_P3;
                else if (dscore <= 4'd5)       w_next = S_D3;
                else                           w_next = S_DONE;
            end
            S_P3:     w_next = S_EVAL_B;
            S_EVAL_B: w_next = w_dealer_draws ? S_D3 : S_DONE;
            S_D3:     w_next = S_DONE;
            S_DONE:   w_next = S_DONE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Moore outputs. The lights also depend on the live scores, but only in DONE.
    always_comb begin
        load_pcard1      = (r_state == S_P1);
        load_dcard1      = (r_state == S_D1);
        load_pcard2      = (r_state == S_P2);
        load_dcard2      = (r_state == S_D2);
        load_pcard3      = (r_state == S_P3);
        load_dcard3      = (r_state == S_D3);
        player_win_light = (r_state == S_DONE) && (pscore >= dscore);
        dealer_win_light = (r_state == S_DONE) && (dscore >= pscore);
    end

endmodule

// File: tb/tb_deal_controller.sv
// -----------------------------------------------------------------------------
// tb_deal_controller
//
// Directed bench for the baccarat deal controller. All eight outputs are
// packed into one vector:
//   {load_pcard1, load_dcard1, load_pcard2, load_dcard2,
//    load_pcard3, load_dcard3, player_win_light, dealer_win_light}
// The bench compares that vector against hand-computed constants. Inputs are
// driven and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_deal_controller;

    logic       slow_clock;
    logic       resetb;
    logic [3:0] pscore;
    logic [3:0] dscore;
    logic [3:0] pcard3;
    logic       load_pcard1, load_pcard2, load_pcard3;
    logic       load_dcard1, load_dcard2, load_dcard3;
    logic       player_win_light, dealer_win_light;

    int n_cmp;
    int n_err;

    // Expected output patterns
    localparam logic [7:0] O_NONE = 8'b000000_00;
    localparam logic [7:0] O_P1   = 8'b100000_00;
    localparam logic [7:0] O_D1   = 8'b010000_00;
    localparam logic [7:0] O_P2   = 8'b001000_00;
    localparam logic [7:0] O_D2   = 8'b000100_00;
    localparam logic [7:0] O_P3   = 8'b000010_00;
    localparam logic [7:0] O_D3   = 8'b000001_00;
    localparam logic [7:0] O_PWIN = 8'b000000_10;
    localparam logic [7:0] O_DWIN = 8'b000000_01;
    localparam logic [7:0] O_TIE  = 8'b000000_11;

    deal_controller dut (
        .slow_clock       (slow_clock),
        .resetb           (resetb),
        .pscore           (pscore),
        .dscore           (dscore),
        .pcard3           (pcard3),
        .load_pcard1      (load_pcard1),
        .load_pcard2      (load_pcard2),
        .load_pcard3      (load_pcard3),
        .load_dcard1      (load_dcard1),
        .load_dcard2      (load_dcard2),
        .load_dcard3      (load_dcard3),
        .player_win_light (player_win_light),
        .dealer_win_light (dealer_win_light)
    );

    // Clock and reset
    initial begin
        slow_clock = 1'b0;
        forever #5 slow_clock = ~slow_clock;
    end

    function automatic logic [7:0] outs();
        return {load_pcard1, load_dcard1, load_pcard2, load_dcard2,
                load_pcard3, load_dcard3, player_win_light, dealer_win_light};
    endfunction

    task automatic check_eq(input string tag, input logic [7:0] obs,
                            input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle on the falling edge
    task automatic tick();
        @(posedge slow_clock);
        @(negedge slow_clock);
    endtask

    task automatic tick_check(input string tag, input logic [7:0] exp);
        tick();
        check_eq(tag, outs(), exp);
    endtask

    // Reset for two edges, release, then deal four cards and land in EVAL
    task automatic deal(input string tag);
        resetb = 1'b0;
        @(posedge slow_clock);
        @(posedge slow_clock);
        @(negedge slow_clock);
        check_eq({tag, "_rst"}, outs(), O_NONE);
        resetb = 1'b1;
        tick_check({tag, "_p1"}, O_P1);
        tick_check({tag, "_d1"}, O_D1);
        tick_check({tag, "_p2"}, O_P2);
        tick_check({tag, "_d2"}, O_D2);
        tick_check({tag, "_eval"}, O_NONE);
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        resetb = 1'b0;
        pscore = 4'd0;
        dscore = 4'd0;
        pcard3 = 4'd0;
        #1;
        check_eq("por", outs(), O_NONE);

        // Natural: 8 vs 3. DONE on edge 6, player only.
        deal("nat");
        pscore = 4'd8; dscore = 4'd3;
        tick_check("nat_done", O_PWIN);
        tick_check("nat_hold", O_PWIN);

        // Player draws 6 and dealer on 5 draws. Final 2 vs 9, dealer only.
        deal("pd");
        pscore = 4'd4; dscore = 4'd5;
        tick_check("pd_p3", O_P3);
        pcard3 = 4'd6;
        tick_check("pd_evalb", O_NONE);
        tick_check("pd_d3", O_D3);
        pscore = 4'd2; dscore = 4'd9;
        tick_check("pd_done", O_DWIN);

        // Queen counts as 0. Dealer on 3 draws.
        deal("fq3");
        pscore = 4'd3; dscore = 4'd3; pcard3 = 4'd12;
        tick_check("fq3_p3", O_P3);
        tick_check("fq3_evalb", O_NONE);
        tick_check("fq3_d3", O_D3);
        tick_check("fq3_done", O_TIE);

        // Queen with the dealer on 4: the dealer stands (3 vs 4, dealer only).
        deal("fq4");
        pscore = 4'd3; dscore = 4'd4; pcard3 = 4'd12;
        tick_check("fq4_p3", O_P3);
        tick_check("fq4_evalb", O_NONE);
        tick_check("fq4_done", O_DWIN);

        // Third card 8 with the dealer on 3: the dealer stands (3 vs 3, tie).
        deal("e83");
        pscore = 4'd3; dscore = 4'd3; pcard3 = 4'd8;
        tick_check("e83_p3", O_P3);
        tick_check("e83_evalb", O_NONE);
        tick_check("e83_done", O_TIE);

        // Dealer on 6 with third card 7 draws (boundary of the 6 rule).
        deal("d67");
        pscore = 4'd2; dscore = 4'd6; pcard3 = 4'd7;
        tick_check("d67_p3", O_P3);
        tick_check("d67_evalb", O_NONE);
        tick_check("d67_d3", O_D3);
        tick_check("d67_done", O_DWIN);

        // Dealer on 7 always stands.
        deal("d7");
        pscore = 4'd1; dscore = 4'd7; pcard3 = 4'd6;
        tick_check("d7_p3", O_P3);
        tick_check("d7_evalb", O_NONE);
        tick_check("d7_done", O_DWIN);

        // Player stands on 7 and the dealer on 5 draws directly (DONE on edge 7).
        deal("ps");
        pscore = 4'd7; dscore = 4'd5;
        tick_check("ps_d3", O_D3);
        tick_check("ps_done", O_PWIN);

        // Both stand on 6: tie.
        deal("tie");
        pscore = 4'd6; dscore = 4'd6;
        tick_check("tie_done", O_TIE);

        // Asynchronous reset while in P3
        deal("ar");
        pscore = 4'd0; dscore = 4'd0;
        tick_check("ar_p3", O_P3);
        #2 resetb = 1'b0;
        #1 check_eq("ar_drop", outs(), O_NONE);
        tick();
        check_eq("ar_held", outs(), O_NONE);
        tick();
        check_eq("ar_held2", outs(), O_NONE);
        resetb = 1'b1;
        tick_check("ar_p1", O_P1);
        tick_check("ar_d1", O_D1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
